ahb_multichan_slave: RTL and testbench
======================================

# ahb_multichan_slave

AHB-Lite slave that generalises the team's single-channel FIFO slave to NUMCHAN independent buffer channels, each with a TX FIFO (bus to user) and an RX FIFO (user to bus). It also provides a CSR file with true byte/halfword lane writes, a status register, and a proper two-cycle ERROR response. It sits between the AHB fabric and user logic; user logic drives stream ports and has random read access to the CSRs.

## Interface
- ADDRESSWIDTH, 32, HADDR width
- DATAWIDTH, 32, bus/FIFO/CSR data width (fixed at 32 for lane logic)
- NUMCHAN, 2, buffer channels, 1..8
- NUMREGS, 8, CSR words
- FIFO_DEPTH, 16, entries per FIFO, power of 2, ≥2
- STALL_ON_FULL, 1, 1 = stall on TX full / RX empty; 0 = ERROR response instead
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- HSEL, HADDR, HWRITE, HSIZE[2:0], HTRANS[1:0], HREADY, HWDATA  in  AHB-Lite slave inputs
- HREADYOUT  out  1  data-phase ready
- HRESP  out  2  2'b00 OKAY, 2'b01 ERROR
- HRDATA  out  32  read data
- tx_valid, tx_ready  out/in  NUMCHAN  per-channel TX stream handshake
- tx_data  out  NUMCHAN*32  channel c at [32c+31:32c]
- rx_valid, rx_ready  in/out  NUMCHAN  per-channel RX stream handshake
- rx_data  in  NUMCHAN*32  packed as tx_data
- u_addr  in  $clog2(NUMREGS)  user CSR index
- u_read_data  out  32  CSR[u_addr], combinational

## Operation
- Transfers are accepted when HSEL & HREADY & HTRANS[1] (NONSEQ/SEQ). IDLE/BUSY get zero-wait OKAY.
- Address map (word index w = HADDR>>2):
  - w < NUMCHAN: write pushes TX[w]; read pops RX[w].
  - w = NUMCHAN: STATUS, read-only. Bit 2c = TX[c] full; bit 2c+1 = RX[c] empty; bits [31:16] = 0.
  - NUMCHAN < w ≤ NUMCHAN+NUMREGS: CSR[w-NUMCHAN-1], read/write.
- ERROR conditions:
  - w beyond the map.
  - Misalignment: HSIZE=1 with HADDR[0]=1, or HSIZE=2 with HADDR[1:0]≠0.
  - HSIZE>2.
  - Write to STATUS.
  - FIFO access with HSIZE≠2.
  - With STALL_ON_FULL=0 only: TX full on write, RX empty on read, judged at the data phase.
- CSR writes are little-endian and update only the addressed lanes:
  - byte at HADDR[1:0];
  - halfword at lanes {HADDR[1],0}+1:{HADDR[1],0};
  - word updates all four lanes.
- CSR reads always return the full 32-bit word.
- FIFOs: count register of width $clog2(FIFO_DEPTH)+1. full = (count==FIFO_DEPTH); empty = (count==0).
  - Push and pop in the same cycle are both honoured and count is unchanged.
  - No write-through: a push into an empty FIFO is visible to the reader next cycle.
- TX user side: tx_valid = !empty; tx_data = head; pop on tx_valid & tx_ready.
- RX user side: rx_ready = !full; push on rx_valid & rx_ready.

## Timing
- Address phase is registered. Data phase is the following cycle(s).
- HWDATA is sampled in the data phase on the cycle HREADYOUT=1.
- TX write with STALL_ON_FULL=1:
  - HREADYOUT=0 while TX[c] full.
  - Push occurs in the first cycle with TX[c] not full, together with HREADYOUT=1.
- RX read with STALL_ON_FULL=1:
  - HREADYOUT=0 while RX[c] empty.
  - In the completing cycle, HRDATA = RX head and the pop is applied at that clock edge.
- ERROR response:
  - Cycle 1: HREADYOUT=0, HRESP=01.
  - Cycle 2: HREADYOUT=1, HRESP=01.
  - No state changes (no CSR write, no push, no pop).
- HRDATA = 0 outside a completing read data phase.
- CSR write data is visible on a read issued in the next address phase (no hazard stall) and on u_read_data the cycle after the write completes.
- Reset (any time, including mid-stall or mid-error):
  - All FIFOs emptied and all CSRs cleared.
  - Pending phase discarded.
  - HREADYOUT=1, HRESP=00, HRDATA=0, tx_valid=0, rx_ready=1.
  - First transfer accepted in the first cycle after release.

## Test plan
- CSR lanes: word write 0x11223344 to CSR0, then byte write 0xAA at offset+2 (HWDATA=0x00AA0000) → read returns 0x11AA3344; u_addr=0 gives the same value.
- TX backpressure, FIFO_DEPTH=4, tx_ready=0: five word writes to ch1 → first four complete with zero wait states; fifth stalls with HREADYOUT=0 and STATUS bit2=1. Raising tx_ready for 1 cycle → fifth write completes the next cycle; tx_data ch1 order is preserved.
- RX: read ch0 while empty stalls. Then rx_data=0xDEADBEEF with rx_valid pulsed → read completes with HRDATA=0xDEADBEEF in the cycle after the push; STATUS bit1 returns to 1.
- Errors: write to STATUS, halfword at HADDR[0]=1, word to w=NUMCHAN+NUMREGS+1 → each gives the exact two-cycle ERROR sequence and no CSR/FIFO change.
- STALL_ON_FULL=0: read of an empty RX → two-cycle ERROR with no stall; write of a full TX → ERROR and count unchanged.
- Reset asserted during a TX stall with a full FIFO → outputs reach reset values immediately, tx_valid=0, STATUS reads 0xAAAA-masked (all RX-empty bits set, TX-full bits clear) after release.

Source files
------------

// File: rtl/ahb_multichan_slave.sv
// Generic synchronous FIFO with a count register. A pushed entry becomes readable on the next cycle.
// Latency: push to head 1 cycle; push and pop in the same cycle are both honoured.
// Backpressure: push is ignored while full and pop is ignored while empty; the caller gates on full/empty.
module ahb_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
endmodule

// AHB-Lite slave with NUMCHAN TX/RX FIFO channels, a STATUS word and a lane-writable CSR file.
// Latency: registered address phase; zero-wait data phase unless a FIFO stall or a two-cycle ERROR applies.
// Backpressure: HREADYOUT low while TX full / RX empty (STALL_ON_FULL=1), otherwise ERROR; rx_ready = !full.
module ahb_multichan_slave #(
    parameter int ADDRESSWIDTH  = 32,
    parameter int DATAWIDTH     = 32,
    parameter int NUMCHAN       = 2,
    parameter int NUMREGS       = 8,
    parameter int FIFO_DEPTH    = 16,
    parameter int STALL_ON_FULL = 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         HSEL,
    input  logic [ADDRESSWIDTH-1:0]      HADDR,
    input  logic                         HWRITE,
    input  logic [2:0]                   HSIZE,
    input  logic [1:0]                   HTRANS,
    input  logic                         HREADY,
    input  logic [DATAWIDTH-1:0]         HWDATA,
    output logic                         HREADYOUT,
    output logic [1:0]                   HRESP,
    output logic [DATAWIDTH-1:0]         HRDATA,
    output logic [NUMCHAN-1:0]           tx_valid,
    input  logic [NUMCHAN-1:0]           tx_ready,
    output logic [NUMCHAN*DATAWIDTH-1:0] tx_data,
    input  logic [NUMCHAN-1:0]           rx_valid,
    output logic [NUMCHAN-1:0]           rx_ready,
    input  logic [NUMCHAN*DATAWIDTH-1:0] rx_data,
    input  logic [$clog2(NUMREGS)-1:0]   u_addr,
    output logic [DATAWIDTH-1:0]         u_read_data
);
    localparam int  WW    = ADDRESSWIDTH - 2;
    localparam int  CW    = (NUMCHAN > 1) ? $clog2(NUMCHAN) : 1;
    localparam int  RW    = $clog2(NUMREGS);
    localparam bit  STALL = (STALL_ON_FULL != 0);

    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_ERR2} state_t;
    typedef enum logic [1:0] {K_FIFO, K_STATUS, K_CSR} kind_t;

    state_t          state;
    kind_t           ap_kind;
    logic            ap_err;
    logic            ap_write;
    logic [CW-1:0]   ap_chan;
    logic [RW-1:0]   ap_csr;
    logic [1:0]      ap_size;
    logic [1:0]      ap_lo;

    logic [WW-1:0]   a_word;
    kind_t           a_kind;
    logic            a_err;
    logic            accept;
    logic            unused_ok;

    logic [NUMCHAN-1:0]   tx_full;
    logic [NUMCHAN-1:0]   tx_empty;
    logic [NUMCHAN-1:0]   tx_push;
    logic [NUMCHAN-1:0]   rx_full;
    logic [NUMCHAN-1:0]   rx_empty;
    logic [NUMCHAN-1:0]   rx_pop;
    logic [DATAWIDTH-1:0] rx_head [NUMCHAN];
    logic [DATAWIDTH-1:0] csr [NUMREGS];
    logic [DATAWIDTH-1:0] status;
    logic [DATAWIDTH-1:0] rd_word;
    logic [3:0]           lane_mask;

    logic in_dp;
    logic blocked;
    logic dp_err;
    logic dp_go;

    assign unused_ok = &{1'b0, HTRANS[0]};
    assign a_word    = HADDR[ADDRESSWIDTH-1:2];
    assign accept    = HSEL & HREADY & HTRANS[1];

    always_comb begin
        a_kind = K_CSR;
        a_err  = 1'b0;
        if (a_word < WW'(NUMCHAN))
            a_kind = K_FIFO;
        else if (a_word == WW'(NUMCHAN))
            a_kind = K_STATUS;
        if (a_word > WW'(NUMCHAN + NUMREGS))               a_err = 1'b1;
        if (HSIZE > 3'd2)                                  a_err = 1'b1;
        if (HSIZE == 3'd1 && HADDR[0])                     a_err = 1'b1;
        if (HSIZE == 3'd2 && HADDR[1:0] != 2'b00)          a_err = 1'b1;
        if (a_kind == K_STATUS && HWRITE)                  a_err = 1'b1;
        if (a_kind == K_FIFO && HSIZE != 3'd2)             a_err = 1'b1;
    end

    // A FIFO access that cannot complete yet either stalls or, without stalling, becomes an ERROR.
    assign in_dp   = (state == ST_DATA);
    assign blocked = (ap_kind == K_FIFO) & (ap_write ? tx_full[ap_chan] : rx_empty[ap_chan]);
    assign dp_err  = in_dp & (ap_err | (!STALL & blocked));
    assign dp_go   = in_dp & ~ap_err & ~blocked;

    assign HREADYOUT = in_dp ? dp_go : 1'b1;
    assign HRESP     = (dp_err || state == ST_ERR2) ? 2'b01 : 2'b00;
    assign HRDATA    = (dp_go & ~ap_write) ? rd_word : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            ap_kind  <= K_FIFO;
            ap_err   <= 1'b0;
            ap_write <= 1'b0;
            ap_chan  <= '0;
            ap_csr   <= '0;
            ap_size  <= '0;
            ap_lo    <= '0;
        end else begin
            if (accept && (state != ST_DATA || dp_go)) begin
                state    <= ST_DATA;
                ap_kind  <= a_kind;
                ap_err   <= a_err;
                ap_write <= HWRITE;
                ap_chan  <= CW'(a_word);
                ap_csr   <= RW'(a_word - WW'(NUMCHAN + 1));
                ap_size  <= HSIZE[1:0];
                ap_lo    <= HADDR[1:0];
            end else if (dp_err) begin
                state <= ST_ERR2;
            end else if (state == ST_ERR2 || dp_go) begin
                state <= ST_IDLE;
            end
        end
    end

    for (genvar c = 0; c < NUMCHAN; c++) begin : g_chan
        ahb_fifo #(.WIDTH(DATAWIDTH), .DEPTH(FIFO_DEPTH)) u_tx (
            .clk       (clk),
            .reset_n   (reset_n),
            .push      (tx_push[c]),
            .push_data (HWDATA),
            .pop       (tx_valid[c] & tx_ready[c]),
            .head      (tx_data[c*DATAWIDTH +: DATAWIDTH]),
            .full      (tx_full[c]),
            .empty     (tx_empty[c])
        );

        ahb_fifo #(.WIDTH(DATAWIDTH), .DEPTH(FIFO_DEPTH)) u_rx (
            .clk       (clk),
            .reset_n   (reset_n),
            .push      (rx_valid[c] & rx_ready[c]),
            .push_data (rx_data[c*DATAWIDTH +: DATAWIDTH]),
            .pop       (rx_pop[c]),
            .head      (rx_head[c]),
            .full      (rx_full[c]),
            .empty     (rx_empty[c])
        );

        assign tx_valid[c] = ~tx_empty[c];
        assign rx_ready[c] = ~rx_full[c];
        assign tx_push[c]  = dp_go & ap_write  & (ap_kind == K_FIFO) & (ap_chan == CW'(c));
        assign rx_pop[c]   = dp_go & ~ap_write & (ap_kind == K_FIFO) & (ap_chan == CW'(c));
    end

    always_comb begin
        status = '0;
        for (int c = 0; c < NUMCHAN; c++) begin
            status[2*c]   = tx_full[c];
            status[2*c+1] = rx_empty[c];
        end
    end

    always_comb begin
        rd_word = '0;
        case (ap_kind)
            K_FIFO:   rd_word = rx_head[ap_chan];
            K_STATUS: rd_word = status;
            default:  rd_word = csr[ap_csr];
        endcase
    end

    // Little-endian lane select; halfwords sit on lanes 1:0 or 3:2 by HADDR[1].
    always_comb begin
        case (ap_size)
            2'd0:    lane_mask = 4'b0001 << ap_lo;
            2'd1:    lane_mask = ap_lo[1] ? 4'b1100 : 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUMREGS; i++) csr[i] <= '0;
        end else if (dp_go && ap_write && ap_kind == K_CSR) begin
            for (int b = 0; b < 4; b++) begin
                if (lane_mask[b]) csr[ap_csr][8*b +: 8] <= HWDATA[8*b +: 8];
            end
        end
    end

    assign u_read_data = csr[u_addr];
endmodule

// File: tb/tb_ahb_multichan_slave.sv
// Scoreboarded bench: instance A stalls (STALL_ON_FULL=1), instance B errors (STALL_ON_FULL=0), both FIFO_DEPTH=4.
module tb_ahb_multichan_slave;
    localparam logic [31:0] CH0 = 32'h00, CH1 = 32'h04, STATUS = 32'h08;
    localparam logic [31:0] CSR0 = 32'h0C, CSR1 = 32'h10, CSR7 = 32'h28, BEYOND = 32'h2C;

    typedef struct {
        bit          wr;
        bit          err;
        logic [31:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        bus_sel, hsel, hwrite;
    logic [31:0] haddr, hwdata;
    logic [2:0]  hsize;
    logic [1:0]  htrans;
    logic        hready;
    logic        hreadyout_a, hreadyout_b;
    logic [1:0]  hresp_a, hresp_b, hresp_m;
    logic [31:0] hrdata_a, hrdata_b, hrdata_m;
    logic [1:0]  tx_valid_a, tx_ready_a, rx_valid_a, rx_ready_a;
    logic [1:0]  tx_valid_b, tx_ready_b, rx_valid_b, rx_ready_b;
    logic [63:0] tx_data_a, rx_data_a, tx_data_b, rx_data_b;
    logic [2:0]  u_addr;
    logic [31:0] u_rd_a, u_rd_b;

    int          checks = 0;
    int          failures = 0;
    bit          dp_active = 1'b0;
    logic        prev_rdy;
    logic [1:0]  prev_resp;
    exp_t        sbq[$];
    logic [31:0] txq[$];
    exp_t        mon_e;
    int          w;

    always #5 clk = ~clk;

    assign hready   = bus_sel ? hreadyout_b : hreadyout_a;
    assign hresp_m  = bus_sel ? hresp_b : hresp_a;
    assign hrdata_m = bus_sel ? hrdata_b : hrdata_a;

    ahb_multichan_slave #(.FIFO_DEPTH(4), .STALL_ON_FULL(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .HSEL(hsel & ~bus_sel), .HADDR(haddr), .HWRITE(hwrite),
        .HSIZE(hsize), .HTRANS(htrans), .HREADY(hready), .HWDATA(hwdata),
        .HREADYOUT(hreadyout_a), .HRESP(hresp_a), .HRDATA(hrdata_a),
        .tx_valid(tx_valid_a), .tx_ready(tx_ready_a), .tx_data(tx_data_a),
        .rx_valid(rx_valid_a), .rx_ready(rx_ready_a), .rx_data(rx_data_a),
        .u_addr(u_addr), .u_read_data(u_rd_a)
    );

    ahb_multichan_slave #(.FIFO_DEPTH(4), .STALL_ON_FULL(0)) dut_b (
        .clk(clk), .reset_n(reset_n), .HSEL(hsel & bus_sel), .HADDR(haddr), .HWRITE(hwrite),
        .HSIZE(hsize), .HTRANS(htrans), .HREADY(hready), .HWDATA(hwdata),
        .HREADYOUT(hreadyout_b), .HRESP(hresp_b), .HRDATA(hrdata_b),
        .tx_valid(tx_valid_b), .tx_ready(tx_ready_b), .tx_data(tx_data_b),
        .rx_valid(rx_valid_b), .rx_ready(rx_ready_b), .rx_data(rx_data_b),
        .u_addr(u_addr), .u_read_data(u_rd_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic xfer(input bit sel, input bit wr, input logic [31:0] addr, input logic [2:0] size,
                        input logic [31:0] wdata, input logic [31:0] exp_rd, input bit exp_err,
                        output int waits);
        exp_t e;
        bit   done;
        e.wr = wr; e.err = exp_err; e.rdata = exp_rd;
        sbq.push_back(e);
        if (!sel && wr && addr == CH1 && !exp_err) txq.push_back(wdata);
        bus_sel = sel; hsel = 1'b1; htrans = 2'b10; hwrite = wr; haddr = addr; hsize = size;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00; hwdata = wdata; dp_active = 1'b1;
        waits = 0; done = 1'b0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (hready) begin
                done = 1'b1;
                break;
            end
            waits++;
        end
        if (!done) check_eq("xfer_timeout", 32'(waits), 32'd0);
        @(posedge clk); #1;
        dp_active = 1'b0;
    endtask

    // Response monitor: pops one expectation per completed data phase.
    always @(negedge clk) begin
        if (dp_active) begin
            if (hready) begin
                if (sbq.size() == 0) begin
                    check_eq("sb_underflow", 32'(sbq.size()), 32'd1);
                end else begin
                    mon_e = sbq.pop_front();
                    check_eq("hresp", 32'(hresp_m), mon_e.err ? 32'd1 : 32'd0);
                    if (mon_e.err)      check_eq("err_cycle1", {29'b0, prev_rdy, prev_resp}, 32'h1);
                    else if (!mon_e.wr) check_eq("hrdata", hrdata_m, mon_e.rdata);
                end
            end
            prev_rdy  = hready;
            prev_resp = hresp_m;
        end else begin
            prev_rdy  = 1'b1;
            prev_resp = 2'b00;
        end
    end

    // TX ch1 stream monitor on instance A.
    always @(negedge clk) begin
        if (reset_n && tx_valid_a[1] && tx_ready_a[1]) begin
            check_eq("tx_pop_expected", 32'(txq.size() != 0), 32'd1);
            if (txq.size() != 0) check_eq("tx_data_ch1", tx_data_a[63:32], txq.pop_front());
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bus_sel = 1'b0; hsel = 1'b0; hwrite = 1'b0; haddr = '0; hwdata = '0; hsize = 3'd2; htrans = 2'b00;
        tx_ready_a = '0; rx_valid_a = '0; rx_data_a = '0;
        tx_ready_b = '0; rx_valid_b = '0; rx_data_b = '0;
        u_addr = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_hreadyout", 32'(hreadyout_a), 32'd1);
        check_eq("rst_hresp", 32'(hresp_a), 32'd0);
        check_eq("rst_hrdata", hrdata_a, 32'd0);
        check_eq("rst_tx_valid", 32'(tx_valid_a), 32'd0);
        check_eq("rst_rx_ready", 32'(rx_ready_a), 32'd3);
        @(posedge clk); #1;
        reset_n = 1'b1;

        xfer(0, 0, STATUS, 3'd2, 0, 32'h0000_000A, 0, w);
        check_eq("first_xfer_waits", 32'(w), 32'd0);
        @(negedge clk);
        check_eq("hrdata_idle", hrdata_a, 32'd0);
        @(posedge clk); #1;

        // CSR lane writes
        xfer(0, 1, CSR0,     3'd2, 32'h1122_3344, 0, 0, w);
        xfer(0, 1, CSR0 + 2, 3'd0, 32'h00AA_0000, 0, 0, w);
        xfer(0, 0, CSR0,     3'd2, 0, 32'h11AA_3344, 0, w);
        u_addr = 3'd0; #1;
        check_eq("u_csr0", u_rd_a, 32'h11AA_3344);
        xfer(0, 1, CSR1,     3'd2, 32'hFFFF_FFFF, 0, 0, w);
        xfer(0, 1, CSR1 + 2, 3'd1, 32'h5A5A_1234, 0, 0, w);
        xfer(0, 0, CSR1,     3'd2, 0, 32'h5A5A_FFFF, 0, w);
        xfer(0, 1, CSR1,     3'd1, 32'h0000_BEEF, 0, 0, w);
        xfer(0, 0, CSR1,     3'd2, 0, 32'h5A5A_BEEF, 0, w);
        xfer(0, 1, CSR7,     3'd2, 32'hCAFE_F00D, 0, 0, w);
        u_addr = 3'd7; #1;
        check_eq("u_csr7", u_rd_a, 32'hCAFE_F00D);
        xfer(0, 0, CSR7,     3'd2, 0, 32'hCAFE_F00D, 0, w);

        // ERROR responses, no side effects
        xfer(0, 1, STATUS,   3'd2, 32'hFFFF_FFFF, 0, 1, w);
        check_eq("err_status_waits", 32'(w), 32'd1);
        xfer(0, 1, CSR0 + 1, 3'd1, 32'hFFFF_FFFF, 0, 1, w);
        xfer(0, 1, BEYOND,   3'd2, 32'hFFFF_FFFF, 0, 1, w);
        xfer(0, 0, BEYOND,   3'd2, 0, 0, 1, w);
        xfer(0, 1, CSR0,     3'd3, 32'hFFFF_FFFF, 0, 1, w);
        xfer(0, 1, CH1,      3'd0, 32'hFFFF_FFFF, 0, 1, w);
        xfer(0, 0, CSR0,     3'd2, 0, 32'h11AA_3344, 0, w);
        u_addr = 3'd0; #1;
        check_eq("u_csr0_after_err", u_rd_a, 32'h11AA_3344);
        xfer(0, 0, STATUS,   3'd2, 0, 32'h0000_000A, 0, w);

        // TX backpressure on ch1
        for (int i = 0; i < 4; i++) begin
            xfer(0, 1, CH1, 3'd2, 32'h100 + i, 0, 0, w);
            check_eq("tx_nowait", 32'(w), 32'd0);
        end
        xfer(0, 0, STATUS, 3'd2, 0, 32'h0000_000E, 0, w);
        check_eq("tx_valid_full", 32'(tx_valid_a), 32'd2);
        fork
            xfer(0, 1, CH1, 3'd2, 32'h104, 0, 0, w);
            begin
                wait (dp_active);
                @(negedge clk); check_eq("tx_stall0", 32'(hreadyout_a), 32'd0);
                @(negedge clk); check_eq("tx_stall1", 32'(hreadyout_a), 32'd0);
                @(posedge clk); #1 tx_ready_a[1] = 1'b1;
                @(posedge clk); #1 tx_ready_a[1] = 1'b0;
            end
        join
        check_eq("tx_release_waits", 32'(w), 32'd3);
        tx_ready_a[1] = 1'b1;
        repeat (6) @(posedge clk);
        #1 tx_ready_a[1] = 1'b0;
        check_eq("txq_drained", 32'(txq.size()), 32'd0);
        check_eq("tx_valid_drained", 32'(tx_valid_a), 32'd0);

        // RX stall then release
        fork
            xfer(0, 0, CH0, 3'd2, 0, 32'hDEAD_BEEF, 0, w);
            begin
                wait (dp_active);
                @(negedge clk); check_eq("rx_stall0", 32'(hreadyout_a), 32'd0);
                @(negedge clk); check_eq("rx_stall1", 32'(hreadyout_a), 32'd0);
                @(posedge clk); #1 rx_data_a[31:0] = 32'hDEAD_BEEF; rx_valid_a[0] = 1'b1;
                @(posedge clk); #1 rx_valid_a[0] = 1'b0;
            end
        join
        check_eq("rx_release_waits", 32'(w), 32'd3);
        xfer(0, 0, STATUS, 3'd2, 0, 32'h0000_000A, 0, w);

        // RX ordering on ch1 with data already present
        rx_data_a[63:32] = 32'h0000_1111; rx_valid_a[1] = 1'b1;
        @(posedge clk); #1 rx_data_a[63:32] = 32'h0000_2222;
        @(posedge clk); #1 rx_valid_a[1] = 1'b0;
        xfer(0, 0, STATUS, 3'd2, 0, 32'h0000_0002, 0, w);
        xfer(0, 0, CH1, 3'd2, 0, 32'h0000_1111, 0, w);
        check_eq("rx_ready_nowait", 32'(w), 32'd0);
        xfer(0, 0, CH1, 3'd2, 0, 32'h0000_2222, 0, w);
        xfer(0, 0, STATUS, 3'd2, 0, 32'h0000_000A, 0, w);

        // Error-instead-of-stall instance
        xfer(1, 0, CH0, 3'd2, 0, 0, 1, w);
        check_eq("b_rx_empty_err_waits", 32'(w), 32'd1);
        for (int i = 0; i < 4; i++) begin
            xfer(1, 1, CH0, 3'd2, 32'h200 + i, 0, 0, w);
            check_eq("b_tx_nowait", 32'(w), 32'd0);
        end
        xfer(1, 1, CH0, 3'd2, 32'h2FF, 0, 1, w);
        check_eq("b_tx_full_err_waits", 32'(w), 32'd1);
        xfer(1, 0, STATUS, 3'd2, 0, 32'h0000_000B, 0, w);
        check_eq("b_tx_head", tx_data_b[31:0], 32'h200);

        // Reset in the middle of a TX stall
        for (int i = 0; i < 4; i++) xfer(0, 1, CH1, 3'd2, 32'h300 + i, 0, 0, w);
        bus_sel = 1'b0; hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = CH1; hsize = 3'd2;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00; hwdata = 32'h3FF;
        @(negedge clk);
        check_eq("rst_pre_stall", 32'(hreadyout_a), 32'd0);
        #2 reset_n = 1'b0;
        #1;
        txq.delete();
        check_eq("mid_rst_hreadyout", 32'(hreadyout_a), 32'd1);
        check_eq("mid_rst_hresp", 32'(hresp_a), 32'd0);
        check_eq("mid_rst_hrdata", hrdata_a, 32'd0);
        check_eq("mid_rst_tx_valid_a", 32'(tx_valid_a), 32'd0);
        check_eq("mid_rst_tx_valid_b", 32'(tx_valid_b), 32'd0);
        check_eq("mid_rst_rx_ready", 32'(rx_ready_a), 32'd3);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        xfer(0, 0, STATUS, 3'd2, 0, 32'h0000_000A, 0, w);
        check_eq("post_rst_waits", 32'(w), 32'd0);
        xfer(0, 0, CSR0, 3'd2, 0, 32'h0, 0, w);
        u_addr = 3'd7; #1;
        check_eq("post_rst_u_csr7", u_rd_a, 32'h0);

        check_eq("sb_empty", 32'(sbq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
